gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-test sequencer that surrounds the seven-gate combinational block (OR, AND, XOR, NOR, NAND, XNOR, NOT). It drives the gate block's operand inputs, waits a programmable settle time, then samples the gate block's outputs. It compares each output against an internal truth-table model and reports per-gate pass/fail. It is the gate block's upstream driver and downstream consumer in the board-level bring-up design.

## Interface
- `SETTLE_CYCLES`, default 2: cycles operands are held before sampling; legal range 1..15.
- `ERR_W`, default 8: width of the saturating mismatch counter.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `op_a`  out  7  bit i drives a(i+1) of the gate block, i = 0..6.
- `op_b`  out  6  bit i drives b(i+1) of the gate block, i = 0..5.
- `y_in`  in  7  bit i is y(i+1) returned from the gate block.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  last completed run had no mismatch.
- `fail_mask`  out  7  sticky per-gate mismatch flags; bit i corresponds to y(i+1).
- `err_cnt`  out  `ERR_W`  number of vectors with at least one mismatching bit; saturates at all-ones.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE:** if `start`=1, clear `fail_mask`, `err_cnt` and `pass`. Set vector index k=0 and go to DRIVE.
- **DRIVE:** holds operands for `SETTLE_CYCLES` cycles, then goes to SAMPLE.
- **SAMPLE:** compares `y_in` against the expected value for one cycle.
  - If k=3, go to DONE.
  - Otherwise k←k+1 and go to DRIVE.
- **DONE:** asserts `done` for one cycle, updates `pass` = (`fail_mask`==0), then returns to IDLE.
- **Operand pattern:** each gate gets a distinct combination so that cross-wired inputs are detected.
  - For gate i (0..6), c = (k+i) mod 4.
  - a = c[1], b = c[0].
  - `op_b` has no bit for gate 7.
- **Expected output** for gate i, in order: a|b, a&b, a^b, ~(a|b), ~(a&b), ~(a^b), ~a.
- **Mismatch handling:**
  - Mismatch mask m = `y_in` ^ expected.
  - `fail_mask` |= m.
  - If m≠0, `err_cnt` increments by 1, saturating.
- `start` is ignored outside IDLE.
- `op_a`/`op_b` hold their last vector after a run ends; they are 0 after reset.

## Timing
- Reset values: `op_a`=0, `op_b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `err_cnt`=0, state IDLE, k=0.
- Let E0 be the edge that accepts `start`, and S = `SETTLE_CYCLES`.
  - `busy` rises at E0.
  - Vector k operands are valid from edge E0+k(S+1).
- Comparison for vector k happens in the cycle following edge E0+k(S+1)+S. The results are registered at edge E0+(k+1)(S+1).
- `done`=1 and `busy`=0 from edge E0+4(S+1)+1 for exactly one cycle. `pass` is valid from that same edge.
  - With S=2, `done` rises 13 edges after E0.
- `y_in` is sampled in SAMPLE only. The gate block must settle within S cycles.
- A reset during a run aborts immediately. All outputs return to reset values and no `done` is issued.

## Configuration
- Macro: `GATE_EXERCISER_STOP_ON_FAIL_EN`.
- **Defined:** if m≠0 in SAMPLE, the FSM goes directly to DONE regardless of k. `err_cnt` is then at most 1.
- **Undefined:** all 4 vectors always run.

## Test plan
- **Correct gate model, S=2:** pulse `start` → `busy` for 13 cycles, `done` pulse, `pass`=1, `fail_mask`=0, `err_cnt`=0.
- **Model y6 computed as ~(a4^b4):** → `fail_mask`=7'b0100000, `err_cnt`=4, `pass`=0.
  - Repeat with `GATE_EXERCISER_STOP_ON_FAIL_EN` → `done` after the first vector, `err_cnt`=1.
- **`y_in` tied to 0, `ERR_W`=2:** → `fail_mask`=7'h7F, `err_cnt`=3 (saturated), `pass`=0.
- **`start` held high for the whole run:** → exactly one run executes; a new run starts only on the cycle after `done`, in IDLE.
- **Deassert `rst_n` during vector 2:** → all outputs go to 0 asynchronously, no `done`. The next `start` runs cleanly with `pass`=1.
- **S=1 and S=15 with a correct model:** → `done` at E0+9 and E0+65 respectively, `pass`=1.

Source files
------------

// File: rtl/gate_exerciser_if.sv
// Bundle between the gate exerciser, its controller and the seven-gate block under test.
interface gate_exerciser_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic [6:0]       op_a;
    logic [5:0]       op_b;
    logic [6:0]       y_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [6:0]       fail_mask;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        input  start,
        input  y_in,
        output op_a,
        output op_b,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output err_cnt
    );

    modport slave (
        output start,
        output y_in,
        input  op_a,
        input  op_b,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  err_cnt
    );
endinterface

// File: rtl/gate_exerciser.sv
// Self-test sequencer for the seven-gate block: drives 4 operand vectors, checks results.
// Optional GATE_EXERCISER_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module gate_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 8
) (
    input logic               clk,
    input logic               rst_n,
    gate_exerciser_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    state_e           state_q;
    logic [1:0]       k_q;
    logic [3:0]       settle_q;
    logic [6:0]       op_a_q;
    logic [5:0]       op_b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [6:0]       fail_mask_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [6:0]       mismatch;

    // Gate i sees combination c = (k + i) mod 4 so neighbouring gates never share operands.
    function automatic logic [6:0] vec_a(input logic [1:0] k);
        logic [6:0] a;
        logic [1:0] c;
        for (int i = 0; i < 7; i++) begin
            c    = k + 2'(i);
            a[i] = c[1];
        end
        return a;
    endfunction

    function automatic logic [5:0] vec_b(input logic [1:0] k);
        logic [5:0] b;
        logic [1:0] c;
        for (int i = 0; i < 6; i++) begin
            c    = k + 2'(i);
            b[i] = c[0];
        end
        return b;
    endfunction

    function automatic logic [6:0] expected(input logic [1:0] k);
        logic [6:0] a;
        logic [5:0] b;
        logic [6:0] e;
        a    = vec_a(k);
        b    = vec_b(k);
        e[0] = a[0] | b[0];
        e[1] = a[1] & b[1];
        e[2] = a[2] ^ b[2];
        e[3] = ~(a[3] | b[3]);
        e[4] = ~(a[4] & b[4]);
        e[5] = ~(a[5] ^ b[5]);
        e[6] = ~a[6];
        return e;
    endfunction

    always_comb begin
        mismatch = bus.y_in ^ expected(k_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= 2'd0;
            settle_q    <= 4'd0;
            op_a_q      <= 7'd0;
            op_b_q      <= 6'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 7'd0;
            err_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        fail_mask_q <= 7'd0;
                        err_cnt_q   <= '0;
                        pass_q      <= 1'b0;
                        k_q         <= 2'd0;
                        settle_q    <= 4'd0;
                        op_a_q      <= vec_a(2'd0);
                        op_b_q      <= vec_b(2'd0);
                        busy_q      <= 1'b1;
                        state_q     <= StDrive;
                    end
                end
                StDrive: begin
                    if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                        settle_q <= 4'd0;
                        state_q  <= StSample;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                StSample: begin
                    fail_mask_q <= fail_mask_q | mismatch;
                    if (mismatch != 7'd0 && err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + ERR_W'(1);
                    end
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
                    if (k_q == 2'd3 || mismatch != 7'd0) begin
`else
                    if (k_q == 2'd3) begin
`endif
                        state_q <= StDone;
                    end else begin
                        k_q     <= k_q + 2'd1;
                        op_a_q  <= vec_a(k_q + 2'd1);
                        op_b_q  <= vec_b(k_q + 2'd1);
                        state_q <= StDrive;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (fail_mask_q == 7'd0);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: a behavioural gate block with injectable faults
// feeds four DUT instances (S=2, S=1, S=15, ERR_W=2 with y tied low).
module tb_gate_exerciser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;

    int n_checks = 0;
    int n_fail = 0;

    int d_main, d_s1, d_s15, d_e2, busy_cnt, done_cnt;

    always #5 clk = ~clk;

    gate_exerciser_if #(.ERR_W(8)) if_main ();
    gate_exerciser_if #(.ERR_W(8)) if_s1 ();
    gate_exerciser_if #(.ERR_W(8)) if_s15 ();
    gate_exerciser_if #(.ERR_W(2)) if_e2 ();

    gate_exerciser #(.SETTLE_CYCLES(2), .ERR_W(8)) u_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
    gate_exerciser #(.SETTLE_CYCLES(1), .ERR_W(8)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if_s1));
    gate_exerciser #(.SETTLE_CYCLES(15), .ERR_W(8)) u_s15 (.clk(clk), .rst_n(rst_n), .bus(if_s15));
    gate_exerciser #(.SETTLE_CYCLES(2), .ERR_W(2)) u_e2 (.clk(clk), .rst_n(rst_n), .bus(if_e2));

    // Gate block model; m selects an injected fault (0 = healthy).
    function automatic logic [6:0] gate_model(input logic [6:0] a, input logic [5:0] b, input int m);
        logic [6:0] y;
        y[0] = a[0] | b[0];
        y[1] = a[1] & b[1];
        y[2] = a[2] ^ b[2];
        y[3] = ~(a[3] | b[3]);
        y[4] = ~(a[4] & b[4]);
        y[5] = ~(a[5] ^ b[5]);
        y[6] = ~a[6];
        case (m)
            1: y[5] = ~(a[3] ^ b[3]);
            2: y = 7'h00;
            3: y = 7'h7F;
            4: y[0] = 1'b1;
            default: ;
        endcase
        return y;
    endfunction

    assign if_main.start = start;
    assign if_s1.start   = start;
    assign if_s15.start  = start;
    assign if_e2.start   = start;
    assign if_main.y_in  = gate_model(if_main.op_a, if_main.op_b, mode);
    assign if_s1.y_in    = gate_model(if_s1.op_a, if_s1.op_b, 0);
    assign if_s15.y_in   = gate_model(if_s15.op_a, if_s15.op_b, 0);
    assign if_e2.y_in    = 7'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start, then track every instance until all have signalled done (bounded).
    task automatic run(input int m);
        mode = m;
        d_main = -1; d_s1 = -1; d_s15 = -1; d_e2 = -1;
        busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_at_e0", 32'(if_main.busy), 32'd1);
        check("op_a_vec0", 32'(if_main.op_a), 32'h4C);
        check("op_b_vec0", 32'(if_main.op_b), 32'h2A);
        busy_cnt = 1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            #1;
            if (if_main.busy) busy_cnt++;
            if (if_main.done) done_cnt++;
            if (if_main.done && d_main < 0) d_main = e;
            if (if_s1.done && d_s1 < 0) d_s1 = e;
            if (if_s15.done && d_s15 < 0) d_s15 = e;
            if (if_e2.done && d_e2 < 0) d_e2 = e;
            if (d_main >= 0 && d_s1 >= 0 && d_s15 >= 0 && d_e2 >= 0) break;
        end
    endtask

    typedef struct {
        int         mode;
        logic       exp_pass;
        logic [6:0] exp_mask;
        logic [7:0] exp_err;
        int         exp_done;
    } vec_t;

    vec_t tbl[5];

    initial begin
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
        tbl[0] = '{0, 1'b1, 7'h00, 8'd0, 13};
        tbl[1] = '{1, 1'b0, 7'h20, 8'd1, 4};
        tbl[2] = '{2, 1'b0, 7'h14, 8'd1, 4};
        tbl[3] = '{3, 1'b0, 7'h6B, 8'd1, 4};
        tbl[4] = '{4, 1'b0, 7'h01, 8'd1, 4};
`else
        tbl[0] = '{0, 1'b1, 7'h00, 8'd0, 13};
        tbl[1] = '{1, 1'b0, 7'h20, 8'd4, 13};
        tbl[2] = '{2, 1'b0, 7'h7F, 8'd4, 13};
        tbl[3] = '{3, 1'b0, 7'h7F, 8'd4, 13};
        tbl[4] = '{4, 1'b0, 7'h01, 8'd1, 13};
`endif

        // Reset values
        #12;
        check("rst_op_a", 32'(if_main.op_a), 32'd0);
        check("rst_op_b", 32'(if_main.op_b), 32'd0);
        check("rst_busy", 32'(if_main.busy), 32'd0);
        check("rst_done", 32'(if_main.done), 32'd0);
        check("rst_pass", 32'(if_main.pass), 32'd0);
        check("rst_mask", 32'(if_main.fail_mask), 32'd0);
        check("rst_err", 32'(if_main.err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            run(tbl[r].mode);
            check($sformatf("row%0d_done_edge", r), 32'(d_main), 32'(tbl[r].exp_done));
            check($sformatf("row%0d_done_width", r), 32'(done_cnt), 32'd1);
            check($sformatf("row%0d_busy_cycles", r), 32'(busy_cnt), 32'(tbl[r].exp_done));
            check($sformatf("row%0d_pass", r), 32'(if_main.pass), 32'(tbl[r].exp_pass));
            check($sformatf("row%0d_fail_mask", r), 32'(if_main.fail_mask), 32'(tbl[r].exp_mask));
            check($sformatf("row%0d_err_cnt", r), 32'(if_main.err_cnt), 32'(tbl[r].exp_err));
            check($sformatf("row%0d_busy_end", r), 32'(if_main.busy), 32'd0);
        end

        // Settle-time extremes, saturating counter, operand hold after the run.
        run(0);
        check("s1_done_edge", 32'(d_s1), 32'd9);
        check("s1_pass", 32'(if_s1.pass), 32'd1);
        check("s15_done_edge", 32'(d_s15), 32'd65);
        check("s15_pass", 32'(if_s15.pass), 32'd1);
        check("op_a_hold", 32'(if_main.op_a), 32'h19);
        check("op_b_hold", 32'(if_main.op_b), 32'h15);
        check("e2_pass", 32'(if_e2.pass), 32'd0);
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
        check("e2_done_edge", 32'(d_e2), 32'd4);
        check("e2_fail_mask", 32'(if_e2.fail_mask), 32'h14);
        check("e2_err_cnt", 32'(if_e2.err_cnt), 32'd1);
`else
        check("e2_done_edge", 32'(d_e2), 32'd13);
        check("e2_fail_mask", 32'(if_e2.fail_mask), 32'h7F);
        check("e2_err_cnt", 32'(if_e2.err_cnt), 32'd3);
`endif

        // start held high: one run, restart only on the edge after done.
        mode = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            #1;
            if (e <= 12 && if_main.done) done_cnt++;
            if (e == 12) check("held_busy_e12", 32'(if_main.busy), 32'd1);
            if (e == 13) begin
                check("held_done_e13", 32'(if_main.done), 32'd1);
                check("held_busy_e13", 32'(if_main.busy), 32'd0);
            end
            if (e == 14) begin
                check("held_restart_busy", 32'(if_main.busy), 32'd1);
                check("held_restart_done", 32'(if_main.done), 32'd0);
            end
        end
        start = 1'b0;
        check("held_no_early_done", 32'(done_cnt), 32'd0);
        done_cnt = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (if_main.done) done_cnt++;
        end
        check("held_second_run_dones", 32'(done_cnt), 32'd1);

        // Asynchronous reset in the middle of vector 2.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_mask", 32'(if_main.fail_mask), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_op_a", 32'(if_main.op_a), 32'd0);
        check("arst_op_b", 32'(if_main.op_b), 32'd0);
        check("arst_busy", 32'(if_main.busy), 32'd0);
        check("arst_mask", 32'(if_main.fail_mask), 32'd0);
        check("arst_err", 32'(if_main.err_cnt), 32'd0);
        check("arst_pass", 32'(if_main.pass), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        done_cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (if_main.done) done_cnt++;
        end
        check("arst_no_done", 32'(done_cnt), 32'd0);
        run(0);
        check("post_rst_done_edge", 32'(d_main), 32'd13);
        check("post_rst_pass", 32'(if_main.pass), 32'd1);
        check("post_rst_err", 32'(if_main.err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
